eth_tx: RTL and testbench

RMII transmit framer. It accepts frame bytes (destination MAC through payload, no FCS) over a valid/ready byte stream and serialises them onto the 2-bit RMII TXD/TX_EN pins. Around the payload it inserts the preamble and SFD, zero-pads short frames to the Ethernet minimum, computes and appends the CRC-32 FCS, and enforces the inter-packet gap. It is the transmit counterpart of the RMII receive path and shares its 50 MHz RMII clock domain.

---
 rtl/eth_tx.sv | 187 ++++++++++++++++++
 tb/tb_eth_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx.sv
// RMII transmit framer: preamble/SFD insertion, zero padding, CRC-32 FCS
// and inter-packet gap around a valid/ready byte stream.
module eth_tx #(
    parameter int pPREAMBLE_BYTES  = 7,
    parameter int pMIN_FRAME_BYTES = 60,
    parameter int pIPG_BYTES       = 12
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    input  logic       Tx_Last,
    output logic       Tx_Ready,
    output logic [1:0] Txd,
    output logic       Tx_En,
    output logic       Busy,
    output logic       Underrun
);

    typedef enum logic [2:0] {
        sIdle,
        sPreamble,
        sSfd,
        sData,
        sPad,
        sFcs,
        sIpg
    } state_t;

    localparam logic [31:0] cPoly     = 32'hEDB8_8320;
    localparam logic [7:0]  cPreByte  = 8'h55;
    localparam logic [7:0]  cSfdByte  = 8'hD5;
    localparam logic [15:0] cPreLast  = 16'(pPREAMBLE_BYTES - 1);
    localparam logic [15:0] cIpgLast  = 16'(4 * pIPG_BYTES - 1);
    localparam logic [10:0] cMin      = 11'(pMIN_FRAME_BYTES);

    state_t      state;
    logic [1:0]  dibitCnt;
    logic [15:0] cnt;
    logic [10:0] byteCnt;
    logic        lastByte;
    logic [31:0] shiftReg;
    logic [31:0] crc;
    logic [31:0] crcNext;
    logic [31:0] fcsWord;
    logic        start;

    // Two reflected CRC steps, low bit of the dibit first.
    function automatic logic [31:0] crcDibit(input logic [31:0] c,
                                             input logic [1:0]  d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 2; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]} ^ (fb ? cPoly : 32'h0);
        end
        return r;
    endfunction

    assign crcNext = crcDibit(crc, Txd);
    assign fcsWord = ~crcNext;

    // A pending frame may start straight out of the last IPG cycle.
    assign start = Tx_Valid &&
                   (state == sIdle ||
                    (state == sIpg && cnt == cIpgLast));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= sIdle;
            dibitCnt <= 2'd0;
            cnt      <= 16'd0;
            byteCnt  <= 11'd0;
            lastByte <= 1'b0;
            shiftReg <= 32'h0;
            crc      <= 32'h0;
            Txd      <= 2'b00;
            Tx_En    <= 1'b0;
            Tx_Ready <= 1'b0;
            Busy     <= 1'b0;
            Underrun <= 1'b0;
        end else begin
            Tx_Ready <= 1'b0;
            Underrun <= 1'b0;
            Txd      <= shiftReg[1:0];
            shiftReg <= {2'b00, shiftReg[31:2]};
            dibitCnt <= dibitCnt + 2'd1;
            if (state == sData || state == sPad)
                crc <= crcNext;

            if (start) begin
                state    <= sPreamble;
                dibitCnt <= 2'd0;
                cnt      <= 16'd0;
                byteCnt  <= 11'd0;
                lastByte <= 1'b0;
                Txd      <= cPreByte[1:0];
                shiftReg <= {26'h0, cPreByte[7:2]};
                Tx_En    <= 1'b1;
                Busy     <= 1'b1;
            end else if (Tx_Ready) begin
                if (Tx_Valid) begin
                    state    <= sData;
                    lastByte <= Tx_Last;
                    byteCnt  <= (byteCnt == 11'h7FF) ?
                                byteCnt : byteCnt + 11'd1;
                    Txd      <= Tx_Data[1:0];
                    shiftReg <= {26'h0, Tx_Data[7:2]};
                end else begin
                    state    <= sIpg;
                    cnt      <= 16'd0;
                    Tx_En    <= 1'b0;
                    Txd      <= 2'b00;
                    shiftReg <= 32'h0;
                    Underrun <= 1'b1;
                end
            end else begin
                unique case (state)
                    sIdle: begin
                        Txd      <= 2'b00;
                        dibitCnt <= 2'd0;
                    end
                    sPreamble: begin
                        if (dibitCnt == 2'd3) begin
                            if (cnt == cPreLast) begin
                                state    <= sSfd;
                                crc      <= 32'hFFFF_FFFF;
                                Txd      <= cSfdByte[1:0];
                                shiftReg <= {26'h0, cSfdByte[7:2]};
                            end else begin
                                cnt      <= cnt + 16'd1;
                                Txd      <= cPreByte[1:0];
                                shiftReg <= {26'h0, cPreByte[7:2]};
                            end
                        end
                    end
                    sSfd: begin
                        if (dibitCnt == 2'd2)
                            Tx_Ready <= 1'b1;
                    end
                    sData, sPad: begin
                        if (state == sData && dibitCnt == 2'd2 && !lastByte)
                            Tx_Ready <= 1'b1;
                        if (dibitCnt == 2'd3) begin
                            if (byteCnt < cMin) begin
                                state    <= sPad;
                                byteCnt  <= byteCnt + 11'd1;
                                Txd      <= 2'b00;
                                shiftReg <= 32'h0;
                            end else begin
                                state    <= sFcs;
                                cnt      <= 16'd0;
                                Txd      <= fcsWord[1:0];
                                shiftReg <= {2'b00, fcsWord[31:2]};
                            end
                        end
                    end
                    sFcs: begin
                        if (dibitCnt == 2'd3) begin
                            if (cnt == 16'd3) begin
                                state <= sIpg;
                                cnt   <= 16'd0;
                                Tx_En <= 1'b0;
                                Txd   <= 2'b00;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    sIpg: begin
                        Txd <= 2'b00;
                        if (cnt == cIpgLast) begin
                            state <= sIdle;
                            cnt   <= 16'd0;
                            Busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= sIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx.sv
// Directed bench for eth_tx: framing, padding, FCS residue, IPG,
// underrun abort and mid-frame reset.
module tb_eth_tx;

    localparam int LOGN = 4096;
    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Last;
    logic       Tx_Ready;
    logic [1:0] Txd;
    logic       Tx_En;
    logic       Busy;
    logic       Underrun;

    always #5 Clk = ~Clk;

    eth_tx dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tx_Data  (Tx_Data),
        .Tx_Valid (Tx_Valid),
        .Tx_Last  (Tx_Last),
        .Tx_Ready (Tx_Ready),
        .Txd      (Txd),
        .Tx_En    (Tx_En),
        .Busy     (Busy),
        .Underrun (Underrun)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] strm [0:511];
    logic       strmLast [0:511];
    int         strmLen;
    int         idx;
    int         dropAt;
    bit         dropNow;
    bit         prevTake;
    int         strobes;

    logic       lEn    [0:LOGN-1];
    logic       lBusy  [0:LOGN-1];
    logic       lReady [0:LOGN-1];
    logic       lUr    [0:LOGN-1];
    logic [1:0] lTxd   [0:LOGN-1];
    int         cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crcByte(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    task automatic drive();
        Tx_Valid = (idx < strmLen) && !dropNow;
        Tx_Data  = (idx < strmLen) ? strm[idx] : 8'h00;
        Tx_Last  = (idx < strmLen) ? strmLast[idx] : 1'b0;
        prevTake = Tx_Ready && Tx_Valid;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        if (prevTake) idx++;
        if (cyc < LOGN) begin
            lEn[cyc]    = Tx_En;
            lBusy[cyc]  = Busy;
            lReady[cyc] = Tx_Ready;
            lUr[cyc]    = Underrun;
            lTxd[cyc]   = Txd;
        end
        if (Tx_Ready) begin
            strobes++;
            if (strobes == dropAt) dropNow = 1'b1;
        end
        cyc++;
        drive();
    endtask

    task automatic clearLog();
        cyc      = 0;
        strobes  = 0;
        dropAt   = 0;
        dropNow  = 1'b0;
        idx      = 0;
        prevTake = 1'b0;
        strmLen  = 0;
    endtask

    task automatic addFrame(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            strm[strmLen + i]     = 8'(seed + i);
            strmLast[strmLen + i] = (i == n - 1);
        end
        strmLen += n;
    endtask

    task automatic analyzeFrame(input string tag, input int from,
                                input int off, input int n,
                                output int rise, output int fall);
        int len, expLen, nb, preErr, dataErr, padded, p;
        logic [1:0]  expd;
        logic [7:0]  b, eb;
        logic [31:0] crc;
        rise = -1;
        for (int c = from; c < cyc; c++)
            if (lEn[c] === 1'b1) begin
                rise = c;
                break;
            end
        if (rise < 0) begin
            check({tag, " rise"}, 32'd0, 32'd1);
            fall = from;
            return;
        end
        fall = rise;
        while (fall < cyc && lEn[fall] === 1'b1) fall++;
        len    = fall - rise;
        padded = (n < 60) ? 60 : n;
        expLen = 4 * (8 + padded + 4);
        check({tag, " len"}, 32'(len), 32'(expLen));
        preErr = 0;
        for (int k = 0; k < 32; k++) begin
            expd = (k == 31) ? 2'b11 : 2'b01;
            if (lTxd[rise + k] !== expd) preErr++;
        end
        check({tag, " preamble"}, 32'(preErr), 32'd0);
        nb = len / 4 - 8;
        if (nb < 4) nb = 4;
        dataErr = 0;
        crc = 32'hFFFF_FFFF;
        for (int j = 0; j < nb; j++) begin
            p = rise + 32 + 4 * j;
            b = {lTxd[p + 3], lTxd[p + 2], lTxd[p + 1], lTxd[p]};
            crc = crcByte(crc, b);
            if (j < padded) begin
                eb = (j < n) ? strm[off + j] : 8'h00;
                if (b !== eb) dataErr++;
            end
        end
        check({tag, " payload"}, 32'(dataErr), 32'd0);
        check({tag, " residue"}, crc, RESIDUE);
    endtask

    task automatic strobeStats(input int from, input int to,
                               output int n, output int first,
                               output int gapBad);
        int last;
        n = 0;
        first = -1;
        gapBad = 0;
        last = -1;
        for (int c = from; c < to; c++)
            if (lReady[c] === 1'b1) begin
                n++;
                if (first < 0) first = c;
                if (last >= 0 && c - last != 4) gapBad++;
                last = c;
            end
    endtask

    int r1, f1, r2, f2, n, first, gapBad, viol, urCnt, urAt, enCnt;

    initial begin
        Rst = 1'b1;
        clearLog();
        Tx_Valid = 1'b0;
        Tx_Data  = 8'h00;
        Tx_Last  = 1'b0;
        step();
        step();
        Rst = 1'b0;
        check("rst tx_en", 32'(Tx_En), 32'd0);
        check("rst txd", 32'(Txd), 32'd0);
        check("rst ready", 32'(Tx_Ready), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst underrun", 32'(Underrun), 32'd0);

        viol = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (Tx_En !== 1'b0 || Tx_Ready !== 1'b0 || Busy !== 1'b0 ||
                Underrun !== 1'b0 || Txd !== 2'b00)
                viol++;
        end
        check("idle 1000", 32'(viol), 32'd0);

        // 60-byte frame 0x00..0x3B
        clearLog();
        addFrame(60, 0);
        drive();
        repeat (420) step();
        analyzeFrame("f60", 0, 0, 60, r1, f1);
        strobeStats(0, cyc, n, first, gapBad);
        check("f60 strobes", 32'(n), 32'd60);
        check("f60 strobe gap", 32'(gapBad), 32'd0);
        check("f60 first strobe", 32'(first - r1), 32'd31);
        check("f60 busy in ipg", 32'(lBusy[f1 + 47]), 32'd1);
        check("f60 busy after ipg", 32'(lBusy[f1 + 48]), 32'd0);

        // 14-byte frame, padded to 60
        clearLog();
        addFrame(14, 8'hA0);
        drive();
        repeat (420) step();
        analyzeFrame("f14", 0, 0, 14, r1, f1);
        strobeStats(0, cyc, n, first, gapBad);
        check("f14 strobes", 32'(n), 32'd14);

        // two back-to-back 64-byte frames
        clearLog();
        addFrame(64, 8'h10);
        addFrame(64, 8'h80);
        drive();
        repeat (760) step();
        analyzeFrame("b2b 1", 0, 0, 64, r1, f1);
        analyzeFrame("b2b 2", f1, 64, 64, r2, f2);
        check("b2b gap", 32'(r2 - f1), 32'd48);
        viol = 0;
        for (int c = r1; c < f2; c++)
            if (lBusy[c] !== 1'b1) viol++;
        check("b2b busy", 32'(viol), 32'd0);
        strobeStats(0, cyc, n, first, gapBad);
        check("b2b strobes", 32'(n), 32'd128);

        // underrun at 20th strobe
        clearLog();
        addFrame(30, 8'h05);
        dropAt = 20;
        drive();
        repeat (200) step();
        urCnt = 0;
        urAt = -1;
        enCnt = 0;
        f1 = -1;
        for (int c = 0; c < cyc; c++) begin
            if (lUr[c] === 1'b1) begin
                urCnt++;
                urAt = c;
            end
            if (lEn[c] === 1'b1) enCnt++;
            if (c > 0 && f1 < 0 && lEn[c - 1] === 1'b1 && lEn[c] === 1'b0)
                f1 = c;
        end
        check("ur pulses", 32'(urCnt), 32'd1);
        check("ur en cycles", 32'(enCnt), 32'd108);
        check("ur at fall", 32'(urAt), 32'(f1));
        if (f1 < 0) f1 = 0;
        check("ur busy in ipg", 32'(lBusy[f1 + 47]), 32'd1);
        check("ur busy after", 32'(lBusy[f1 + 48]), 32'd0);

        // reset during FCS, then a fresh frame
        clearLog();
        addFrame(60, 8'h40);
        drive();
        r1 = -1;
        for (int k = 0; k < 20 && r1 < 0; k++) begin
            step();
            if (Tx_En === 1'b1) r1 = cyc - 1;
        end
        if (r1 < 0) begin
            check("rstf rise", 32'd0, 32'd1);
        end else begin
            while (cyc < r1 + 280) step();
            check("rstf in fcs", 32'(Tx_En), 32'd1);
            Rst = 1'b1;
            step();
            Rst = 1'b0;
            check("rstf tx_en", 32'(Tx_En), 32'd0);
            check("rstf txd", 32'(Txd), 32'd0);
            check("rstf busy", 32'(Busy), 32'd0);
            clearLog();
            addFrame(60, 8'h77);
            drive();
            repeat (400) step();
            analyzeFrame("rstf new", 0, 0, 60, r2, f2);
            check("rstf restart", 32'(r2), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
